// File: rtl/adat_encoder_if.sv
// Read port between the ADAT encoder and the M9K circular sample buffer.
// The encoder side issues the strobe and address; the RAM returns one bit a clock later.
interface adat_encoder_if #(
  parameter int CIRC_BUF_BITS = 3
);
  logic                     ram_read_en_o;
  logic [CIRC_BUF_BITS+7:0] ram_read_addr_o;
  logic                     ram_read_data_i;

  modport master (
    output ram_read_en_o,
    output ram_read_addr_o,
    input  ram_read_data_i
  );

  modport slave (
    input  ram_read_en_o,
    input  ram_read_addr_o,
    output ram_read_data_i
  );
endinterface

// File: rtl/adat_encoder.sv
// ADAT optical transmitter: fetches 8 x 24-bit samples bit-serially from the
// circular buffer and sends them as a 256-bit NRZI-coded ADAT frame.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// StIdle     | line quiet, nrzi_o holds; waiting for enable_i at ph==3
// StSyncHead | frame bits 0..11: leading 1, ten-zero sync, trailing 1
// StUser     | frame bits 12..15: user bits, LSB first
// StSamples  | frame bits 16..255: nibbles of 1 lead bit + 4 data bits
module adat_encoder #(
  parameter int CIRC_BUF_BITS = 3
) (
  input  logic                     clk_x4_i,
  input  logic                     reset_ni,
  input  logic                     enable_i,
  input  logic [3:0]               user_bits_i,
  input  logic [CIRC_BUF_BITS-1:0] wr_frame_idx_i,
  adat_encoder_if.master           ram,
  output logic                     nrzi_o,
  output logic                     bit_tick_o,
  output logic                     frame_start_o,
  output logic                     underrun_o,
  output logic [CIRC_BUF_BITS-1:0] rd_frame_idx_o,
  output logic                     active_o
);

  typedef enum logic [1:0] {
    StIdle,
    StSyncHead,
    StUser,
    StSamples
  } state_t;

  state_t                   state;
  logic [1:0]               ph;
  logic [7:0]               b;
  logic [2:0]               nib;
  logic [2:0]               ch;
  logic [4:0]               bitc;
  logic                     live;
  logic [3:0]               user_q;
  logic                     data_q;
  logic                     nrzi;
  logic [CIRC_BUF_BITS-1:0] rd_frame;

  logic decide;
  logic silent_now;
  logic data_bit;
  logic line_bit;

  // The live/silent decision is taken once, in the ph==0 clock of frame bit 0.
  assign decide     = (state == StSyncHead) && (b == 8'd0) && (ph == 2'd0);
  assign silent_now = (rd_frame == wr_frame_idx_i);
  assign data_bit   = (state == StSamples) && (nib != 3'd0);

  // Value of the current frame bit before NRZI coding.
  always_comb begin
    line_bit = 1'b1;
    if (state == StSyncHead) begin
      line_bit = (b == 8'd0) || (b == 8'd11);
    end else if (state == StUser) begin
      line_bit = user_q[b[1:0]];
    end else if (data_bit) begin
      line_bit = live & data_q;
    end
  end

  assign ram.ram_read_en_o   = data_bit && live && (ph == 2'd0);
  assign ram.ram_read_addr_o = {rd_frame, ch, bitc};
  assign bit_tick_o          = (state != StIdle) && (ph == 2'd3);
  assign frame_start_o       = bit_tick_o && (state == StSyncHead) && (b == 8'd0);
  assign underrun_o          = decide && silent_now;
  assign active_o            = (state != StIdle);
  assign nrzi_o              = nrzi;
  assign rd_frame_idx_o      = rd_frame;

  // Free-running bit phase; keeps going in StIdle so frames always start on a bit boundary.
  always_ff @(posedge clk_x4_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ph <= 2'd0;
    end else begin
      ph <= ph + 2'd1;
    end
  end

  // Frame sequencer: state, bit index, sample counters, line register and slot pointer.
  always_ff @(posedge clk_x4_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state    <= StIdle;
      b        <= 8'd0;
      nib      <= 3'd0;
      ch       <= 3'd0;
      bitc     <= 5'd0;
      live     <= 1'b0;
      user_q   <= 4'd0;
      data_q   <= 1'b0;
      nrzi     <= 1'b0;
      rd_frame <= '0;
    end else begin
      if (decide) begin
        live   <= !silent_now;
        user_q <= user_bits_i;
      end
      if (ph == 2'd1) begin
        data_q <= ram.ram_read_data_i;
      end
      if (ph == 2'd3) begin
        if (state != StIdle) begin
          nrzi <= nrzi ^ line_bit;
        end
        // 192 data bits per frame bring ch/bitc back to 0 on their own.
        if (data_bit) begin
          if (bitc == 5'd23) begin
            bitc <= 5'd0;
            ch   <= ch + 3'd1;
          end else begin
            bitc <= bitc + 5'd1;
          end
        end
        case (state)
          StIdle: begin
            if (enable_i) begin
              state <= StSyncHead;
              b     <= 8'd0;
            end
          end
          StSyncHead: begin
            b <= b + 8'd1;
            if (b == 8'd11) state <= StUser;
          end
          StUser: begin
            b <= b + 8'd1;
            if (b == 8'd15) begin
              state <= StSamples;
              nib   <= 3'd0;
            end
          end
          StSamples: begin
            b   <= b + 8'd1;
            nib <= (nib == 3'd4) ? 3'd0 : nib + 3'd1;
            if (b == 8'd255) begin
              if (live) rd_frame <= rd_frame + 1'b1;
              state <= enable_i ? StSyncHead : StIdle;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adat_encoder.sv
// Bench for adat_encoder: random sample buffer and user bits, frames decoded
// from the NRZI line and compared with frames built from the ADAT bit layout.
module tb_adat_encoder;

  logic       clk;
  logic       rst_n;
  logic       enable_i;
  logic [3:0] user_bits_i;
  logic [2:0] wr_frame_idx_i;
  logic       nrzi_o;
  logic       bit_tick_o;
  logic       frame_start_o;
  logic       underrun_o;
  logic [2:0] rd_frame_idx_o;
  logic       active_o;

  adat_encoder_if #(.CIRC_BUF_BITS(3)) ram_if ();

  adat_encoder #(.CIRC_BUF_BITS(3)) dut (
    .clk_x4_i       (clk),
    .reset_ni       (rst_n),
    .enable_i       (enable_i),
    .user_bits_i    (user_bits_i),
    .wr_frame_idx_i (wr_frame_idx_i),
    .ram            (ram_if),
    .nrzi_o         (nrzi_o),
    .bit_tick_o     (bit_tick_o),
    .frame_start_o  (frame_start_o),
    .underrun_o     (underrun_o),
    .rd_frame_idx_o (rd_frame_idx_o),
    .active_o       (active_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // samp[slot][channel] holds a 24-bit sample; buffer bit 0 is the sample MSB
  logic [23:0] samp [8][8];
  int          cyc;
  int          under_cnt;
  logic [10:0] addr_q [$];

  int n_vec;
  int n_miss;

  logic [2:0] m_rd;
  logic [3:0] cur_user;
  int         u_snap;
  int         prev_start;
  bit         have_prev;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM: data valid one clock after the strobe
  always @(posedge clk) begin
    if (ram_if.ram_read_en_o === 1'b1)
      ram_if.ram_read_data_i <= samp[ram_if.ram_read_addr_o[10:8]][ram_if.ram_read_addr_o[7:5]]
                                    [23 - int'(ram_if.ram_read_addr_o[4:0])];
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ram_if.ram_read_en_o === 1'b1) addr_q.push_back(ram_if.ram_read_addr_o);
      if (underrun_o === 1'b1) under_cnt = under_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [255:0] exp_frame(input bit lv, input logic [2:0] s, input logic [3:0] u);
    logic [255:0] f;
    int i, d;
    f = '0;
    f[0]  = 1'b1;
    f[11] = 1'b1;
    for (int k = 0; k < 4; k++) f[12+k] = u[k];
    for (int bb = 16; bb < 256; bb++) begin
      i = bb - 16;
      if (i % 5 == 0) f[bb] = 1'b1;
      else begin
        d = (i / 5) * 4 + (i % 5) - 1;
        f[bb] = lv ? samp[s][d / 24][23 - (d % 24)] : 1'b0;
      end
    end
    return f;
  endfunction

  task automatic wait_frame_start(output bit ok);
    int t;
    t = 0;
    while (frame_start_o !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ok = (t < 3000);
    if (!ok) check("frame_start_timeout", 256'(0), 256'(1));
  endtask

  // Decode one whole frame from the line and check everything observable about it.
  task automatic run_frame(input logic [2:0] next_wr, input bit drop_en);
    logic [255:0] obs;
    logic [2:0]   wr_dec, slot;
    logic [3:0]   usr;
    logic [10:0]  ea;
    logic         p, c;
    bit           live_m, ok;
    int           t, bad, nexp;
    wait_frame_start(ok);
    if (!ok) return;
    if (have_prev) check("frame_period", 256'(cyc - prev_start), 256'(1024));
    prev_start = cyc;
    have_prev  = 1'b1;
    wr_dec = wr_frame_idx_i;
    usr    = cur_user;
    slot   = m_rd;
    live_m = (m_rd != wr_dec);
    check("underrun_pulse", 256'(under_cnt - u_snap), live_m ? 256'(0) : 256'(1));
    wr_frame_idx_i = next_wr;
    cur_user       = 4'($urandom);
    user_bits_i    = cur_user;
    addr_q.delete();
    obs = '0;
    for (int bi = 0; bi < 256; bi++) begin
      if (drop_en && bi == 100) enable_i = 1'b0;
      if (bi == 255) begin
        u_snap = under_cnt;
        nexp   = live_m ? 192 : 0;
        check("ram_read_count", 256'(addr_q.size()), 256'(nexp));
        bad = 0;
        for (int d = 0; d < nexp && d < addr_q.size(); d++) begin
          ea = {slot, 3'(d / 24), 5'(d % 24)};
          if (addr_q[d] !== ea) bad++;
        end
        check("ram_addr_seq", 256'(bad), 256'(0));
      end
      p = nrzi_o;
      @(negedge clk);
      c = nrzi_o;
      obs[bi] = p ^ c;
      if (bi < 255) begin
        t = 0;
        while (bit_tick_o !== 1'b1 && t < 8) begin
          @(negedge clk);
          t++;
        end
        if (t >= 8) begin
          check("bit_tick_timeout", 256'(0), 256'(1));
          break;
        end
      end
    end
    check("frame_bits", obs, exp_frame(live_m, slot, usr));
    if (live_m) m_rd = m_rd + 3'd1;
    check("rd_frame_idx", 256'(rd_frame_idx_o), 256'(m_rd));
    check("active_after_frame", 256'(active_o), 256'(enable_i));
  endtask

  initial begin
    logic nz0;
    bit   chg, ok;
    n_vec = 0; n_miss = 0; cyc = 0; under_cnt = 0;
    m_rd = 3'd0; have_prev = 1'b0; prev_start = 0;
    rst_n = 1'b0; enable_i = 1'b0;
    user_bits_i = 4'b1010; cur_user = 4'b1010;
    wr_frame_idx_i = 3'd1;
    ram_if.ram_read_data_i = 1'b0;

    for (int s = 0; s < 8; s++)
      for (int k = 0; k < 8; k++) samp[s][k] = 24'($urandom);
    for (int k = 0; k < 8; k++) samp[0][k] = 24'h0;
    samp[0][0] = 24'hA5A5A5;
    samp[0][7] = 24'h000001;

    repeat (3) @(negedge clk);
    check("reset_outputs", 256'({ram_if.ram_read_en_o, ram_if.ram_read_addr_o, nrzi_o, bit_tick_o,
                                 frame_start_o, underrun_o, rd_frame_idx_o, active_o}), 256'(0));
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_before_enable", 256'({active_o, nrzi_o}), 256'(0));

    u_snap   = under_cnt;
    enable_i = 1'b1;
    run_frame(3'd1, 1'b0);                 // slot 0 live, fixed samples
    run_frame(3'd0, 1'b0);                 // silent; producer moves mid-frame
    for (int f = 0; f < 7; f++) run_frame(3'd0, 1'b0);   // slots 1..7, wrap to 0
    run_frame(3'd3, 1'b0);                 // rd == wr == 0: silent
    run_frame(3'd3, 1'b1);                 // enable dropped at bit 100

    nz0 = nrzi_o;
    chg = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if (nrzi_o !== nz0 || active_o !== 1'b0 || frame_start_o !== 1'b0) chg = 1'b1;
    end
    check("idle_quiet", 256'(chg), 256'(0));

    have_prev = 1'b0;
    enable_i  = 1'b1;
    wait_frame_start(ok);
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_midframe", 256'({ram_if.ram_read_en_o, ram_if.ram_read_addr_o, nrzi_o, bit_tick_o,
                                  frame_start_o, underrun_o, rd_frame_idx_o, active_o}), 256'(0));
    m_rd     = 3'd0;
    enable_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_after_reset", 256'(active_o), 256'(0));
    enable_i = 1'b1;
    repeat (6) @(negedge clk);
    check("active_on_enable", 256'(active_o), 256'(1));
    u_snap = under_cnt;
    run_frame(3'd3, 1'b0);                 // slot 0 live after reset

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
